// File: rtl/csdf_2f_1p_split.sv
// Receive side of the two-flow pick/accumulate actor: each tagged input token is
// split into four tokens on the flow chosen by its tag; the four tokens sum to the payload.
module csdf_2f_1p_split #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             empty,
  output logic             rd,
  input  logic             full0,
  input  logic             full1,
  output logic             wr0,
  output logic             wr1,
  output logic [WIDTH-1:0] out_data
);

  logic             busy;
  logic             tag_q;
  logic [WIDTH-2:0] q;
  logic [WIDTH-2:0] r;
  logic [1:0]       phase;

  logic [WIDTH-2:0] p_in;
  logic [WIDTH-2:0] q_in;
  logic [WIDTH-2:0] r_in;
  logic             full_sel;
  logic             wr_en;
  logic             last_wr;

  // Remainder share q + P[1:0] never exceeds P, so it fits the payload width.
  always_comb begin
    p_in     = in_data[WIDTH-2:0];
    q_in     = p_in >> 2;
    r_in     = q_in + {{(WIDTH-3){1'b0}}, p_in[1:0]};
    full_sel = tag_q ? full1 : full0;
    wr_en    = !rst && busy && !full_sel;
    last_wr  = wr_en && (phase == 2'd3);
    rd       = !rst && !empty && (!busy || last_wr);
    wr0      = wr_en && !tag_q;
    wr1      = wr_en && tag_q;
    out_data = '0;
    if (wr_en)
      out_data = {1'b0, (phase == 2'd3) ? r : q};
  end

  // A read on the final write reloads directly, so the flow can switch without a bubble.
  always_ff @(posedge ck) begin
    if (rst) begin
      busy  <= 1'b0;
      tag_q <= 1'b0;
      q     <= '0;
      r     <= '0;
      phase <= 2'd0;
    end else if (rd) begin
      busy  <= 1'b1;
      tag_q <= in_data[WIDTH-1];
      q     <= q_in;
      r     <= r_in;
      phase <= 2'd0;
    end else if (wr_en) begin
      phase <= phase + 2'd1;
      if (last_wr)
        busy <= 1'b0;
    end
  end

endmodule
